// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote per bit, parity/framing/break
// flags, and a first-word-fall-through receive FIFO with ready/valid output.
module uart_rx_os #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;
  typedef struct packed {
    logic                 brk;
    logic                 frm;
    logic                 par;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [PW-1:0]        presc_q, presc_d;
  logic [OW-1:0]        os_q, os_d;
  logic [3:0]           bit_q, bit_d;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d, any1_q, any1_d;
  logic                 rx_s, tick, decide, maj, push;
  entry_t               push_entry;

  entry_t               mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 ovr_q, pop, full, wr_en;
  entry_t               head;

  assign rx_s   = sync_q[1];
  assign tick   = (state_q != IDLE) && (presc_q == PW'(DIV - 1));
  assign decide = tick && (os_q == OW'(MID + 1));
  // Third vote is the live sample taken on the decision tick itself.
  assign maj    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    any1_d     = any1_q;
    push       = 1'b0;
    push_entry = '0;
    presc_d    = (state_q == IDLE || tick) ? '0 : presc_q + 1'b1;
    os_d       = os_q;
    if (state_q == IDLE)
      os_d = '0;
    else if (tick)
      os_d = (os_q == OW'(OVERSAMPLE - 1)) ? '0 : os_q + 1'b1;

    unique case (state_q)
      IDLE: if (!rx_s) begin
        state_d   = START;
        bit_d     = '0;
        shift_d   = '0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        any1_d    = 1'b0;
      end
      START: if (decide) state_d = maj ? IDLE : DATA;
      DATA: if (decide) begin
        shift_d = {maj, shift_q[DATA_BITS-1:1]};
        any1_d  = any1_q | maj;
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? PAR : STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      PAR: if (decide) begin
        any1_d    = any1_q | maj;
        par_err_d = maj ^ (^shift_q) ^ (PARITY == 2);
        state_d   = STOP;
      end
      STOP: if (decide) begin
        any1_d    = any1_q | maj;
        frm_err_d = frm_err_q | ~maj;
        if (bit_q == 4'(STOP_BITS - 1)) begin
          push            = 1'b1;
          push_entry.brk  = ~any1_d;
          push_entry.frm  = frm_err_d;
          push_entry.par  = par_err_q;
          push_entry.data = shift_q;
          state_d         = any1_d ? IDLE : BRK_WAIT;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      BRK_WAIT: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still takes the new frame if the head is popped in the same cycle.
  assign pop   = rx_valid & rx_ready;
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      presc_q   <= '0;
      os_q      <= '0;
      bit_q     <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      any1_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], rx};
      presc_q   <= presc_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      if (tick && os_q == OW'(MID - 1)) s0_q <= rx_s;
      if (tick && os_q == OW'(MID))     s1_q <= rx_s;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      any1_q    <= any1_d;
      ovr_q     <= push & full & ~pop;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_entry;
  end

  assign head          = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign rx_valid      = (cnt_q != '0);
  assign rx_data       = head.data;
  assign parity_error  = head.par;
  assign framing_error = head.frm;
  assign break_det     = head.brk;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three frame formats (8N1, 8E1, 7O2) at 32 MHz / 1 Mbaud,
// directed scenarios followed by randomized frames checked against a frame model.
module tb_uart_rx_os;
  localparam int BT = 32;
  localparam int CFG_ND  [3] = '{8, 8, 7};
  localparam int CFG_PAR [3] = '{0, 1, 2};
  localparam int CFG_NS  [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] ready = 3'b000;
  logic [2:0] v, pe, fe, bk, ov;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  int passes = 0;
  int total = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(32000000), .BAUD_RATE(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .rx_data(d0), .rx_valid(v[0]),
    .rx_ready(ready[0]), .parity_error(pe[0]), .framing_error(fe[0]),
    .break_det(bk[0]), .overrun(ov[0]));
  uart_rx_os #(.CLK_FREQ(32000000), .BAUD_RATE(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .rx_data(d1), .rx_valid(v[1]),
    .rx_ready(ready[1]), .parity_error(pe[1]), .framing_error(fe[1]),
    .break_det(bk[1]), .overrun(ov[1]));
  uart_rx_os #(.CLK_FREQ(32000000), .BAUD_RATE(1000000), .OVERSAMPLE(16), .DATA_BITS(7),
               .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .rx_data(d2), .rx_valid(v[2]),
    .rx_ready(ready[2]), .parity_error(pe[2]), .framing_error(fe[2]),
    .break_det(bk[2]), .overrun(ov[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {valid, parity, framing, break, data}
  function automatic logic [11:0] outs(input int w);
    case (w)
      0:       return {v[0], pe[0], fe[0], bk[0], d0};
      1:       return {v[1], pe[1], fe[1], bk[1], d1};
      default: return {v[2], pe[2], fe[2], bk[2], 1'b0, d2};
    endcase
  endfunction

  task automatic chk_head(input string tag, input int w, input logic [7:0] ed,
                          input logic epe, input logic efe, input logic ebk);
    logic [11:0] o;
    o = outs(w);
    chk({tag, "_valid"}, o[11], 1'b1);
    chk({tag, "_data"}, o[7:0], ed);
    chk({tag, "_perr"}, o[10], epe);
    chk({tag, "_ferr"}, o[9], efe);
    chk({tag, "_brk"}, o[8], ebk);
  endtask

  // Line levels of one frame, bit 0 = start bit.
  function automatic logic [15:0] frame(input int w, input logic [8:0] data, input logic pflip,
                                        input logic [1:0] stopv, output int n);
    logic [15:0] f;
    logic [8:0]  dm;
    int i;
    f  = '0;
    i  = 1;
    dm = data & ((9'd1 << CFG_ND[w]) - 9'd1);
    for (int k = 0; k < CFG_ND[w]; k++) begin f[i] = dm[k]; i++; end
    if (CFG_PAR[w] != 0) begin f[i] = (^dm) ^ (CFG_PAR[w] == 2) ^ pflip; i++; end
    for (int k = 0; k < CFG_NS[w]; k++) begin f[i] = stopv[k]; i++; end
    n = i;
    return f;
  endfunction

  // Call at posedge+1; each bit lasts BT clocks. gbit: bit index given a 2-clock glitch.
  task automatic send_bits(input int w, input logic [15:0] bits, input int n, input int gbit);
    for (int k = 0; k < n; k++) begin
      rx_line[w] = bits[k];
      if (k == gbit) begin
        repeat (17) @(posedge clk);
        #1 rx_line[w] = ~bits[k];
        repeat (2) @(posedge clk);
        #1 rx_line[w] = bits[k];
        repeat (BT - 19) @(posedge clk);
        #1;
      end else begin
        repeat (BT) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int w, input logic [8:0] data, input logic pflip,
                            input logic [1:0] stopv, input int gbit);
    logic [15:0] f;
    int n;
    f = frame(w, data, pflip, stopv, n);
    send_bits(w, f, n, gbit);
    rx_line[w] = 1'b1;
  endtask

  task automatic pop(input int w);
    @(negedge clk) ready[w] = 1'b1;
    @(negedge clk) ready[w] = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int w, input int budget);
    logic [11:0] o;
    int c;
    c = 0;
    o = outs(w);
    while (o[11] !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
      o = outs(w);
    end
    chk({tag, "_arrived"}, o[11], 1'b1);
  endtask

  // Reference: error flags follow directly from the levels that were sent.
  task automatic expect_frame(input string tag, input int w, input logic [8:0] data,
                              input logic pflip, input logic [1:0] stopv);
    logic [8:0]  dm;
    logic        pbit, epe, efe, ebk, stops_zero;
    logic [11:0] o;
    dm         = data & ((9'd1 << CFG_ND[w]) - 9'd1);
    pbit       = (^dm) ^ (CFG_PAR[w] == 2) ^ pflip;
    epe        = (CFG_PAR[w] != 0) && pflip;
    efe        = !stopv[0] || (CFG_NS[w] == 2 && !stopv[1]);
    stops_zero = !stopv[0] && (CFG_NS[w] == 1 || !stopv[1]);
    ebk        = (dm == 0) && (CFG_PAR[w] == 0 || !pbit) && stops_zero;
    wait_valid(tag, w, 2000);
    @(negedge clk);
    chk_head(tag, w, dm[7:0], epe, efe, ebk);
    pop(w);
    o = outs(w);
    chk({tag, "_drained"}, o[11], 1'b0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] o;
    logic [15:0] f;
    int cnt, n_ov, nb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    o = outs(0);
    chk("rst_valid", o[11], 1'b0);
    chk("rst_data", o[7:0], 8'h00);
    chk("rst_flags", o[10:8], 3'b000);
    chk("rst_overrun", ov, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 0xA5 with exact valid latency (first high at negedge after edge 311)
    cnt = 0;
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
      begin
        while (v[0] !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
      end
    join
    chk("a5_latency", cnt, 312);
    expect_frame("a5", 0, 9'h0A5, 1'b0, 2'b11);

    // 8E1 0x03 with parity bit flipped to 1
    @(posedge clk); #1;
    send_frame(1, 9'h003, 1'b1, 2'b11, -1);
    expect_frame("e1_par", 1, 9'h003, 1'b1, 2'b11);

    // 7O2 0x55, second stop low
    @(posedge clk); #1;
    send_frame(2, 9'h055, 1'b0, 2'b01, -1);
    repeat (100) @(posedge clk);
    expect_frame("o2_stop", 2, 9'h055, 1'b0, 2'b01);
    repeat (100) @(posedge clk);
    o = outs(2);
    chk("o2_no_extra", o[11], 1'b0);

    // break: 12 bit-times low
    @(posedge clk); #1;
    rx_line[0] = 1'b0;
    repeat (12 * BT) @(posedge clk);
    #1 rx_line[0] = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk_head("brk", 0, 8'h00, 1'b0, 1'b1, 1'b1);
    pop(0);
    repeat (200) @(posedge clk);
    o = outs(0);
    chk("brk_single", o[11], 1'b0);

    // short idle glitch, then a glitch inside data bit 3
    @(posedge clk); #1;
    rx_line[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_line[0] = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    o = outs(0);
    chk("idle_glitch", o[11], 1'b0);
    @(posedge clk); #1;
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 4);
    expect_frame("bit_glitch", 0, 9'h0FF, 1'b0, 2'b11);

    // overrun: five frames into a four-entry FIFO, nobody popping
    @(posedge clk); #1;
    n_ov = 0;
    fork
      for (int i = 0; i < 5; i++) send_frame(0, 9'(8'h10 + i), 1'b0, 2'b11, -1);
      repeat (5 * 10 * BT + 200) begin @(negedge clk); if (ov[0]) n_ov++; end
    join
    chk("ovr_pulses", n_ov, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_head("ovr_order", 0, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      pop(0);
    end
    o = outs(0);
    chk("ovr_empty", o[11], 1'b0);

    // full FIFO with a pop in the push cycle: frame accepted, no overrun
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_frame(0, 9'(8'h20 + i), 1'b0, 2'b11, -1);
    @(posedge clk); #1;
    n_ov = 0;
    fork
      send_frame(0, 9'h024, 1'b0, 2'b11, -1);
      begin
        repeat (310) @(posedge clk);
        @(negedge clk) ready[0] = 1'b1;
        @(negedge clk) ready[0] = 1'b0;
      end
      repeat (400) begin @(negedge clk); if (ov[0]) n_ov++; end
    join
    chk("pushpop_ovr", n_ov, 0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk_head("pushpop_order", 0, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      pop(0);
    end
    o = outs(0);
    chk("pushpop_empty", o[11], 1'b0);

    // reset in the middle of data bit 4 with an entry pending
    @(posedge clk); #1;
    send_frame(0, 9'h077, 1'b0, 2'b11, -1);
    repeat (20) @(posedge clk);
    o = outs(0);
    chk("pre_rst_valid", o[11], 1'b1);
    @(posedge clk); #1;
    f = frame(0, 9'h03C, 1'b0, 2'b11, nb);
    send_bits(0, f, 5, -1);
    rx_line[0] = f[5];
    repeat (16) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    o = outs(0);
    chk("midrst_valid", o[11], 1'b0);
    chk("midrst_data", o[7:0], 8'h00);
    rx_line[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send_frame(0, 9'h03C, 1'b0, 2'b11, -1);
    expect_frame("post_rst", 0, 9'h03C, 1'b0, 2'b11);

    // randomized frames across all three formats
    for (int it = 0; it < 12; it++) begin
      int         w;
      logic [8:0] dat;
      logic       pf;
      logic [1:0] sv;
      int         g;
      w   = it % 3;
      dat = 9'($urandom);
      pf  = (CFG_PAR[w] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sv  = 2'($urandom_range(0, 3));
      g   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, CFG_ND[w])) : -1;
      repeat (64) @(posedge clk);
      #1;
      send_frame(w, dat, pf, sv, g);
      repeat (40) @(posedge clk);
      expect_frame("rand", w, dat, pf, sv);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
